// File: rtl/gate_tester_3in.sv
// Walks a 3-input gate through all 8 vectors, samples after SETTLE_CYCLES, checks against TRUTH_TABLE.
// One run takes 8*(SETTLE_CYCLES+1)+1 cycles after start; start is ignored while busy.
module gate_tester_3in #(
   parameter logic [7:0]  TRUTH_TABLE   = 8'h80,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       o_dut,
   output logic       i0,
   output logic       i1,
   output logic       i2,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] fail_mask,
   output logic [3:0] err_count
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, REPORT} state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state_q;
   logic [2:0] vec_q;
   logic [3:0] cnt_q;
   logic [2:0] drive_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic [7:0] fail_mask_q;
   logic [3:0] err_count_q;
   logic       mismatch;

   assign mismatch = o_dut ^ TRUTH_TABLE[vec_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vec_q       <= 3'd0;
         cnt_q       <= 4'd0;
         drive_q     <= 3'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_mask_q <= 8'h00;
         err_count_q <= 4'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= SETTLE;
                  vec_q       <= 3'd0;
                  cnt_q       <= 4'd0;
                  drive_q     <= 3'd0;
                  busy_q      <= 1'b1;
                  pass_q      <= 1'b0;
                  fail_mask_q <= 8'h00;
                  err_count_q <= 4'd0;
               end
            end
            SETTLE: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= SAMPLE;
                  cnt_q   <= 4'd0;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            SAMPLE: begin
               if (mismatch) begin
                  fail_mask_q[vec_q] <= 1'b1;
                  err_count_q        <= err_count_q + 4'd1;
               end
               if (vec_q != 3'd7) begin
                  state_q <= SETTLE;
                  vec_q   <= vec_q + 3'd1;
                  drive_q <= vec_q + 3'd1;
               end else begin
                  state_q <= REPORT;
                  drive_q <= 3'd0;
                  done_q  <= 1'b1;
               end
            end
            REPORT: begin
               // err_count already includes any vector-7 mismatch from the previous cycle
               state_q <= IDLE;
               busy_q  <= 1'b0;
               pass_q  <= (err_count_q == 4'd0);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign i0        = drive_q[0];
   assign i1        = drive_q[1];
   assign i2        = drive_q[2];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = fail_mask_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_tester_3in.sv
// Scoreboard bench: drivers queue expected reports, monitors check them when done pulses.
module tb_gate_tester_3in;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic [1:0] mode_a = 2'd0;  // 0: AND gate, 1: stuck at 0, 2: stuck at 1

   logic       i0_a, i1_a, i2_a, busy_a, done_a, pass_a, o_dut_a;
   logic [7:0] fail_mask_a;
   logic [3:0] err_count_a;
   logic       i0_b, i1_b, i2_b, busy_b, done_b, pass_b, o_dut_b;
   logic [7:0] fail_mask_b;
   logic [3:0] err_count_b;

   assign o_dut_a = (mode_a == 2'd0) ? (i0_a & i1_a & i2_a) : (mode_a == 2'd2);
   assign o_dut_b = i0_b | i1_b | i2_b;

   gate_tester_3in dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .o_dut(o_dut_a),
      .i0(i0_a), .i1(i1_a), .i2(i2_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .fail_mask(fail_mask_a), .err_count(err_count_a)
   );

   gate_tester_3in #(.TRUTH_TABLE(8'hFE), .SETTLE_CYCLES(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .o_dut(o_dut_b),
      .i0(i0_b), .i1(i1_b), .i2(i2_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .fail_mask(fail_mask_b), .err_count(err_count_b)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   typedef struct {
      int         done_edge;
      logic       pass;
      logic [7:0] mask;
      logic [3:0] err;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // Monitor for instance A
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done_a === 1'b1) begin
            chk("a_done_expected", 32'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
               e = q_a.pop_front();
               chk("a_done_edge", edge_n, e.done_edge);
               chk("a_fail_mask", fail_mask_a, e.mask);
               chk("a_err_count", err_count_a, e.err);
               @(negedge clk);
               chk("a_pass", pass_a, e.pass);
            end
         end
      end
   end

   // Monitor for instance B
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done_b === 1'b1) begin
            chk("b_done_expected", 32'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
               e = q_b.pop_front();
               chk("b_done_edge", edge_n, e.done_edge);
               chk("b_fail_mask", fail_mask_b, e.mask);
               chk("b_err_count", err_count_b, e.err);
               @(negedge clk);
               chk("b_pass", pass_b, e.pass);
            end
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 150 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("drain_a", q_a.size(), 0);
      chk("drain_b", q_b.size(), 0);
   endtask

   // Pulses start on A; s is the edge that accepts it. Spec cycle 25 == edge s+24.
   task automatic launch_a(input bit push, input logic p, input logic [7:0] m,
                           input logic [3:0] e, output int s);
      exp_t x;
      @(negedge clk);
      start_a = 1'b1;
      s = edge_n + 1;
      if (push) begin
         x.done_edge = s + 24; x.pass = p; x.mask = m; x.err = e;
         q_a.push_back(x);
      end
      @(negedge clk);
      start_a = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      int   s;
      int   off;
      exp_t x;

      #1;
      chk("reset_a", {i2_a, i1_a, i0_a, busy_a, done_a, pass_a, fail_mask_a, err_count_a}, 0);
      chk("reset_b", {i2_b, i1_b, i0_b, busy_b, done_b, pass_b, fail_mask_b, err_count_b}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // T1: AND gate against AND table
      mode_a = 2'd0;
      launch_a(1, 1'b1, 8'h00, 4'd0, s);
      drain();

      // T2: stuck at 0, plus input walk and an ignored mid-run start
      mode_a = 2'd1;
      launch_a(1, 1'b0, 8'h80, 4'd1, s);
      chk("t2_pass_cleared", pass_a, 0);
      while (edge_n < s + 24) begin
         @(negedge clk);
         off = edge_n - s;
         start_a = (off == 10);
         if (off % 3 == 2) chk("t2_vec_walk", {i2_a, i1_a, i0_a}, (off - 2) / 3);
      end
      chk("t2_report_inputs", {i2_a, i1_a, i0_a}, 0);
      drain();
      chk("t2_no_rerun", busy_a, 0);

      // T3: stuck at 1
      mode_a = 2'd2;
      launch_a(1, 1'b0, 8'h7F, 4'd7, s);
      drain();

      // T4: OR gate, OR table, one settle cycle
      @(negedge clk);
      start_b = 1'b1;
      s = edge_n + 1;
      x.done_edge = s + 16; x.pass = 1'b1; x.mask = 8'h00; x.err = 4'd0;
      q_b.push_back(x);
      @(negedge clk);
      start_b = 1'b0;
      drain();

      // T5: reset during vector 4 settle
      mode_a = 2'd0;
      launch_a(0, 1'b0, 8'h00, 4'd0, s);
      while (edge_n < s + 12) @(negedge clk);
      chk("t5_vec4", {i2_a, i1_a, i0_a}, 4);
      rst_n = 1'b0;
      #1;
      chk("t5_reset_a", {i2_a, i1_a, i0_a, busy_a, done_a, pass_a, fail_mask_a, err_count_a}, 0);
      chk("t5_reset_b_pass", pass_b, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("t5_idle_after_reset", busy_a, 0);
      launch_a(1, 1'b1, 8'h00, 4'd0, s);
      drain();

      // T6: start held high, back-to-back runs
      @(negedge clk);
      start_a = 1'b1;
      s = edge_n + 1;
      x.done_edge = s + 24; x.pass = 1'b1; x.mask = 8'h00; x.err = 4'd0;
      q_a.push_back(x);
      x.done_edge = s + 50;
      q_a.push_back(x);
      while (edge_n < s + 50) begin
         @(negedge clk);
         off = edge_n - s;
         chk("t6_busy", busy_a, 32'(off != 25));
         if (off == 50) start_a = 1'b0;
      end
      drain();
      chk("t6_idle_at_end", busy_a, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
